half_precision_multiplier_seq: RTL and testbench
================================================

// Module: half_precision_multiplier_seq
// PURPOSE
//  Multi-cycle IEEE-754 binary16 multiplier; stage directly downstream of operand classification.
//  Accepts two raw fp16 operands over valid/ready, classifies them and normalises subnormals.
//  Multiplies the 11-bit significands by iterative shift-add (one bit per cycle).
//  Rounds round-to-nearest-even and emits the packed fp16 result over valid/ready.
// PARAMETERS
//  MUL_BITS  11  significand width incl. hidden bit; sets MUL iteration count (fixed for fp16)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   async active-low reset
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   block idle, can accept
//  a          in   16  operand A, raw fp16
//  b          in   16  operand B, raw fp16
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer takes result
//  result     out  16  packed fp16 product
//  flags      out  4   {invalid,overflow,underflow,inexact}; only with FP16_MUL_FLAGS_EN
// BEHAVIOUR
//  Reset: async on rst_n low; state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, all regs 0.
//   Reset mid-operation aborts it silently; no partial result is emitted.
//  FSM: IDLE -> (accept & special) SPEC | (accept) MUL -> NORM -> RND -> DONE -> IDLE.
//  Accept = in_valid & in_ready; in_ready=1 only in IDLE. a/b are captured on accept, ignored otherwise.
//  Special: either operand NaN/inf/zero -> SPEC (1 cycle) -> DONE. out_valid is high 2 cycles after the accept edge.
//  Finite nonzero: MUL 11 cycles (cnt 0..10, 22-bit acc), NORM 1, RND 1. out_valid is high 14 cycles after the accept edge.
//  DONE: out_valid=1; result/flags held stable until out_ready=1, then IDLE. No accept in the same cycle; min period 15 cycles.
//  Classify (raw bits): exp=31 & frac!=0 NaN (frac[9]=0 sNaN); exp=31 & frac=0 inf;
//   exp=0 & frac=0 zero; exp=0 & frac!=0 subnormal; otherwise normal (incl. frac=0).
//  Unpack: normal -> {1,frac}, e=exp-15; subnormal -> left-shift to hidden 1, e=-14-shift. e is 7-bit signed.
//  Sign = sa^sb for every non-NaN result.
//  Special results: any NaN -> 16'h7E00; inf*0 -> 16'h7E00 + invalid; sNaN input -> invalid.
//   inf*nonzero -> signed inf; zero*finite -> signed zero.
//  NORM: product in [1,4); if p[21] then shift right 1 (shifted bit -> sticky) and e+1. Biased E=e+15 (8-bit signed).
//  E<=0: right-shift (1-E) with sticky, E=0; shift>=13 collapses all bits to sticky.
//  RND: RNE on guard/round/sticky; significand carry-out -> E+1 (subnormal may become normal 0x0400).
//  E>=31 after rounding -> signed inf 0x7C00/0xFC00, overflow+inexact.
//  inexact = any discarded bit nonzero; underflow = tiny (pre-round E<=0) & inexact.
// CONFIGURATION
//  FP16_MUL_FLAGS_EN defined: flags port and flag logic present; flags update together with result.
//  Undefined: flags port absent; no flag registers. result and timing identical to the defined case.
// STRUCTURE
//  Package fp16_pkg: BIAS=15, EXP_W=5, FRAC_W=10, QNAN=16'h7E00, PINF=16'h7C00,
//   state enum {IDLE,SPEC,MUL,NORM,RND,DONE}, flag bit indices, function fp16_classify.
//  Sub-module fp16_round_pack (combinational): {sign, E, 14-bit sig+g/r/s} -> result + overflow/inexact.
//  Top: FSM, operand regs, shift-add datapath, subnormal pre-normaliser.
// TESTING
//  0x3C00*0x4000 -> 0x4000, flags 0, out_valid exactly 14 cycles after accept.
//  0x3C01*0x3E00 -> 0x3E02 (tie, odd, rounds up); 0x3C03*0x3E00 -> 0x3E04 (tie, even); both inexact.
//  0x7BFF*0x4000 -> 0x7C00, overflow+inexact; 0xFBFF*0x4000 -> 0xFC00.
//  0x0001*0x3C00 -> 0x0001, flags 0; 0x0001*0x3800 -> 0x0000, underflow+inexact; 0x03FF*0x3C00 -> 0x03FF.
//  0x7C00*0x0000 -> 0x7E00 invalid; 0x7D00*0x3C00 -> 0x7E00 invalid; 0x8000*0x3C00 -> 0x8000; each 2-cycle latency.
//  out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; rst_n low during MUL -> out_valid=0, then next op correct.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared constants, FSM state encodings and operand classification for the fp16 multiplier.
package fp16_pkg;

  localparam int unsigned BIAS   = 15;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StSpec = 3'd1;
  localparam logic [2:0] StMul  = 3'd2;
  localparam logic [2:0] StNorm = 3'd3;
  localparam logic [2:0] StRnd  = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  localparam logic [2:0] ClsZero = 3'd0;
  localparam logic [2:0] ClsSub  = 3'd1;
  localparam logic [2:0] ClsNorm = 3'd2;
  localparam logic [2:0] ClsInf  = 3'd3;
  localparam logic [2:0] ClsQnan = 3'd4;
  localparam logic [2:0] ClsSnan = 3'd5;

  // Takes the magnitude bits only; the sign never affects the class.
  function automatic logic [2:0] fp16_classify(input logic [14:0] mag);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e = mag[FRAC_W +: EXP_W];
    f = mag[FRAC_W-1:0];
    if (e == '1) begin
      if (f == '0)     return ClsInf;
      else if (f[9])   return ClsQnan;
      else             return ClsSnan;
    end else if (e == '0) begin
      return (f == '0) ? ClsZero : ClsSub;
    end
    return ClsNorm;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even and pack of a normalised fp16 significand with guard/round/sticky.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic        sign,
  input  logic [7:0]  biased_exp,
  input  logic [13:0] sig,
  output logic [15:0] result,
  output logic        overflow,
  output logic        inexact
);

  logic [10:0] man;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [11:0] sum;
  logic [7:0]  exp_r;

  always_comb begin
    man      = sig[13:3];
    guard    = sig[2];
    sticky   = |sig[1:0];
    round_up = guard & (sticky | man[0]);
    sum      = {1'b0, man} + {11'b0, round_up};
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    exp_r    = biased_exp + {7'b0, sum[11]} + {7'b0, (biased_exp == 8'd0) & sum[10]};
    overflow = (exp_r >= 8'd31);
    inexact  = guard | sticky | overflow;
    if (overflow) begin
      result = {sign, PINF[14:0]};
    end else if (sum[11]) begin
      result = {sign, exp_r[4:0], 10'b0};
    end else begin
      result = {sign, exp_r[4:0], sum[9:0]};
    end
  end

endmodule

// File: rtl/half_precision_multiplier_seq.sv
// Multi-cycle fp16 multiplier: shift-add significand product, RNE rounding, valid/ready handshake.
// Optional exception flags port enabled by defining FP16_MUL_FLAGS_EN.
module half_precision_multiplier_seq
  import fp16_pkg::*;
#(
  parameter int unsigned MUL_BITS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FP16_MUL_FLAGS_EN
  output logic [3:0]  flags,
`endif
  output logic [15:0] result
);

  logic [2:0]         state_q, state_d;
  logic [15:0]        a_q, b_q;
  logic [3:0]         cnt_q;
  logic [10:0]        mcand_q, mplier_q;
  logic [21:0]        acc_q;
  logic signed [7:0]  exp_q;
  logic               sign_q;
  logic [13:0]        sig_q;
  logic [15:0]        result_q;

  logic               accept;
  logic               in_special;
  logic [2:0]         cls_a_in, cls_b_in, cls_a, cls_b;
  logic [17:0]        up_a, up_b;

  // Returns {7-bit signed unbiased exponent, 11-bit significand with hidden bit set}.
  function automatic logic [17:0] fp16_unpack(input logic [14:0] mag);
    logic [3:0]  sh;
    logic [6:0]  e;
    logic [10:0] s;
    sh = '0;
    if (mag[14:10] != 5'd0) begin
      s = {1'b1, mag[9:0]};
      e = {2'b00, mag[14:10]} - 7'(BIAS);
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (mag[i]) sh = 4'(10 - i);
      end
      s = {1'b0, mag[9:0]} << sh;
      e = 7'(-14) - {3'b000, sh};
    end
    return {e, s};
  endfunction

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

  assign cls_a_in   = fp16_classify(a[14:0]);
  assign cls_b_in   = fp16_classify(b[14:0]);
  assign in_special = !(cls_a_in inside {ClsSub, ClsNorm}) || !(cls_b_in inside {ClsSub, ClsNorm});
  assign up_a       = fp16_unpack(a[14:0]);
  assign up_b       = fp16_unpack(b[14:0]);
  assign cls_a      = fp16_classify(a_q[14:0]);
  assign cls_b      = fp16_classify(b_q[14:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = in_special ? StSpec : StMul;
      StSpec: state_d = StDone;
      StMul:  if (cnt_q == 4'(MUL_BITS - 1)) state_d = StNorm;
      StNorm: state_d = StRnd;
      StRnd:  state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Special-operand result, consumed in StSpec.
  logic [15:0] spec_result;
  logic        spec_invalid;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  always_comb begin
    nan_a  = (cls_a == ClsQnan) || (cls_a == ClsSnan);
    nan_b  = (cls_b == ClsQnan) || (cls_b == ClsSnan);
    inf_a  = (cls_a == ClsInf);
    inf_b  = (cls_b == ClsInf);
    zero_a = (cls_a == ClsZero);
    zero_b = (cls_b == ClsZero);
    spec_invalid = 1'b0;
    if (nan_a || nan_b) begin
      spec_result  = QNAN;
      spec_invalid = (cls_a == ClsSnan) || (cls_b == ClsSnan);
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      spec_result  = QNAN;
      spec_invalid = 1'b1;
    end else if (inf_a || inf_b) begin
      spec_result = {a_q[15] ^ b_q[15], PINF[14:0]};
    end else begin
      spec_result = {a_q[15] ^ b_q[15], 15'd0};
    end
  end

  // Normalisation of the raw product plus denormalising right shift, consumed in StNorm.
  logic [20:0]        nsig;
  logic               nsticky;
  logic signed [7:0]  e_biased, e_final;
  logic [7:0]         dsh;
  logic [13:0]        pre, den;
  logic               norm_tiny;

  always_comb begin
    if (acc_q[21]) begin
      nsig    = acc_q[21:1];
      nsticky = acc_q[0];
    end else begin
      nsig    = acc_q[20:0];
      nsticky = 1'b0;
    end
    e_biased  = exp_q + 8'(BIAS) + {7'b0, acc_q[21]};
    pre       = {nsig[20:8], |{nsig[7:0], nsticky}};
    dsh       = 8'd1 - e_biased;
    den       = pre;
    e_final   = e_biased;
    norm_tiny = 1'b0;
    if (e_biased <= 8'sd0) begin
      norm_tiny = 1'b1;
      e_final   = 8'sd0;
      if (dsh >= 8'd14) begin
        den = {13'b0, |pre};
      end else begin
        den = (pre >> dsh) | {13'b0, |(pre & ~(14'h3fff << dsh))};
      end
    end
  end

  logic [15:0] rp_result;
  logic        rp_overflow;
  logic        rp_inexact;

  fp16_round_pack u_round_pack (
    .sign       (sign_q),
    .biased_exp (exp_q),
    .sig        (sig_q),
    .result     (rp_result),
    .overflow   (rp_overflow),
    .inexact    (rp_inexact)
  );

`ifdef FP16_MUL_FLAGS_EN
  logic [3:0] flags_q;
  logic       tiny_q;
  assign flags = flags_q;
`else
  logic unused_flag_sources;
  assign unused_flag_sources = ^{spec_invalid, norm_tiny, rp_overflow, rp_inexact};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sig_q    <= '0;
      result_q <= '0;
`ifdef FP16_MUL_FLAGS_EN
      flags_q  <= '0;
      tiny_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            sign_q   <= a[15] ^ b[15];
            mcand_q  <= up_a[10:0];
            mplier_q <= up_b[10:0];
            exp_q    <= {up_a[17], up_a[17:11]} + {up_b[17], up_b[17:11]};
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        StSpec: begin
          result_q <= spec_result;
`ifdef FP16_MUL_FLAGS_EN
          flags_q  <= {spec_invalid, 3'b000};
`endif
        end
        StMul: begin
          acc_q <= acc_q + (mplier_q[cnt_q] ? ({11'b0, mcand_q} << cnt_q) : 22'd0);
          cnt_q <= cnt_q + 4'd1;
        end
        StNorm: begin
          sig_q  <= den;
          exp_q  <= e_final;
`ifdef FP16_MUL_FLAGS_EN
          tiny_q <= norm_tiny;
`endif
        end
        StRnd: begin
          result_q <= rp_result;
`ifdef FP16_MUL_FLAGS_EN
          flags_q[FlagInvalid]   <= 1'b0;
          flags_q[FlagOverflow]  <= rp_overflow;
          flags_q[FlagUnderflow] <= tiny_q & rp_inexact;
          flags_q[FlagInexact]   <= rp_inexact;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_half_precision_multiplier_seq.sv
// Scoreboard bench for half_precision_multiplier_seq: directed corner cases plus randomized operands.
module tb_half_precision_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
`ifdef FP16_MUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  half_precision_multiplier_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP16_MUL_FLAGS_EN
    .flags     (flags),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_req = 0;
  bit   random_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = m * 2^k exactly, then rounded to the fp16 grid with plain integer arithmetic.
  function automatic logic [19:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, mx, my, kx, ky, k, msb, top, e, sh;
    logic [9:0] fx, fy;
    longint m, n, rem, half;
    logic s, nan_x, nan_y, snan, inex, tiny;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    fx = x[9:0];
    fy = y[9:0];
    s  = x[15] ^ y[15];
    nan_x = (ex == 31) && (fx != 0);
    nan_y = (ey == 31) && (fy != 0);
    snan  = (nan_x && !fx[9]) || (nan_y && !fy[9]);
    if (nan_x || nan_y) return {snan ? 4'b1000 : 4'b0000, 16'h7E00};
    if ((ex == 31 && y[14:0] == 0) || (ey == 31 && x[14:0] == 0)) return {4'b1000, 16'h7E00};
    if (ex == 31 || ey == 31) return {4'b0000, s, 15'h7C00};
    if (x[14:0] == 0 || y[14:0] == 0) return {4'b0000, s, 15'h0000};
    mx = (ex != 0) ? 1024 + int'(fx) : int'(fx);
    my = (ey != 0) ? 1024 + int'(fy) : int'(fy);
    kx = (ex != 0) ? ex - 25 : -24;
    ky = (ey != 0) ? ey - 25 : -24;
    m  = longint'(mx) * longint'(my);
    k  = kx + ky;
    msb = 0;
    for (int i = 0; i < 23; i++) if (m[i]) msb = i;
    top = msb + k;
    e   = (top < -14) ? -14 : top;
    sh  = e - 10 - k;
    if (sh > 0) begin
      n    = m >> sh;
      rem  = m - (n << sh);
      half = longint'(1) << (sh - 1);
    end else begin
      n    = m << (-sh);
      rem  = 0;
      half = 1;
    end
    if (rem > half || (rem == half && n[0])) n++;
    if (n == 2048) begin
      n = 1024;
      e++;
    end
    inex = (rem != 0);
    tiny = (top < -14);
    if (n >= 1024) begin
      if (e + 15 >= 31) return {4'b0101, s, 15'h7C00};
      return {3'b000, inex, s, 5'(e + 15), n[9:0]};
    end
    return {2'b00, tiny & inex, inex, s, 5'd0, n[9:0]};
  endfunction

  // Expected latency counts the accept edge itself through the edge that raises out_valid.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input bit push,
                       input logic [15:0] er, input logic [3:0] ef, input int lat);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!in_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 200) begin
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        $fatal(1, "accept timeout");
      end
    end
    if (push) q.push_back('{er, ef, lat, cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic issue_model(input logic [15:0] x, input logic [15:0] y);
    logic [19:0] r;
    bit special;
    r = ref_mul(x, y);
    special = (x[14:10] == 5'd31) || (y[14:10] == 5'd31) || (x[14:0] == 0) || (y[14:0] == 0);
    issue(x, y, 1'b1, r[15:0], r[19:16], special ? 2 : 14);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (q.size() != 0 || !in_ready || out_valid) begin
      @(negedge clk);
      budget++;
      if (budget > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        break;
      end
    end
  endtask

  function automatic logic [15:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(7))
      0: return {r[15], 5'd0, r[9:0]};
      1: return {r[15], 5'(27 + r[12:11]), r[9:0]};
      2: return {r[15], 5'h1F, r[16] ? r[9:0] : 10'd0};
      3: return {r[15], 15'd0};
      4: return {r[15], 5'(1 + r[13:11]), r[9:0]};
      default: return r[15:0];
    endcase
  endfunction

  // Monitor: pops the scoreboard on the first cycle of each result, then checks it holds.
  initial begin
    exp_t cur;
    bit   seen;
    bit   stray;
    int   stall;
    seen  = 0;
    stray = 0;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        out_ready = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            stray = 1;
            $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
            cur = '{result, 4'b0, 0, 0};
          end else begin
            stray = 0;
            cur = q.pop_front();
            check("result", result, cur.res);
`ifdef FP16_MUL_FLAGS_EN
            check("flags", flags, cur.flg);
`endif
            check("latency", cyc - cur.acc + 1, cur.lat);
            check("in_ready_in_done", in_ready, 0);
          end
          stall = stall_req;
          stall_req = 0;
          if (random_stall && $urandom_range(3) == 0) stall = $urandom_range(3, 1);
        end else if (!stray) begin
          check("hold_result", result, cur.res);
          check("hold_in_ready", in_ready, 0);
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          seen = 0;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
    end
  end

  logic [15:0] da [11] = '{16'h3C00, 16'h3C01, 16'h3C03, 16'h7BFF, 16'hFBFF, 16'h0001,
                           16'h0001, 16'h03FF, 16'h7C00, 16'h7D00, 16'h8000};
  logic [15:0] db [11] = '{16'h4000, 16'h3E00, 16'h3E00, 16'h4000, 16'h4000, 16'h3C00,
                           16'h3800, 16'h3C00, 16'h0000, 16'h3C00, 16'h3C00};
  logic [15:0] dr [11] = '{16'h4000, 16'h3E02, 16'h3E04, 16'h7C00, 16'hFC00, 16'h0001,
                           16'h0000, 16'h03FF, 16'h7E00, 16'h7E00, 16'h8000};
  logic [3:0]  df [11] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0000,
                           4'b0011, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
  int          dl [11] = '{14, 14, 14, 14, 14, 14, 14, 14, 2, 2, 2};

  initial begin
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
`ifdef FP16_MUL_FLAGS_EN
    check("reset_flags", flags, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) issue(da[i], db[i], 1'b1, dr[i], df[i], dl[i]);
    wait_idle();

    // Consumer back-pressure while the result sits in DONE.
    stall_req = 5;
    issue(16'h3C00, 16'h4000, 1'b1, 16'h4000, 4'b0000, 14);
    wait_idle();

    // Abort during the multiply; nothing may come out of the aborted operation.
    issue(16'h3C00, 16'h3E00, 1'b0, 16'h0, 4'b0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h3C01, 16'h3E00, 1'b1, 16'h3E02, 4'b0001, 14);
    wait_idle();

    random_stall = 1;
    for (int i = 0; i < 200; i++) issue_model(rand_op(), rand_op());
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
